kernel_bank: RTL

Parametrised, writable successor to the fixed 3x3 kernel ROM. Holds `BANKS` convolution kernels of `KSIZE`x`KSIZE` signed coefficients of `WIDTH` bits each. Provides a byte-addressed random-access read port and a valid/ready streaming port that feeds the MAC datapath one coefficient per cycle. Sits between the host-side register interface and the convolution engine.

---
 rtl/kernel_bank.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/kernel_bank.sv
// rtl/kernel_bank.sv - banked KSIZE x KSIZE convolution kernel store with random read and coefficient stream
// Write port enabled by KERNEL_WRITE_EN; otherwise a constant ROM of the reset kernels.
module kernel_bank #(
  parameter int WIDTH = 16,
  parameter int KSIZE = 3,
  parameter int BANKS = 2,
  localparam int TAPS = KSIZE * KSIZE,
  localparam int AW = $clog2(TAPS),
  localparam int BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             WE,
  input  logic [BW-1:0]    WBANK,
  input  logic [AW+1:0]    WADDR,
  input  logic [WIDTH-1:0] WDATA,
  output logic             WERR,
  input  logic [BW-1:0]    RBANK,
  input  logic [AW+1:0]    ADDRESS,
  output logic [WIDTH-1:0] READ,
  input  logic             START,
  input  logic [BW-1:0]    SBANK,
  output logic [WIDTH-1:0] COEF,
  output logic             COEF_VALID,
  input  logic             COEF_READY,
  output logic             COEF_LAST,
  output logic             BUSY
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t state, state_n;
  logic [AW-1:0]    idx, idx_n;
  logic [BW-1:0]    bank, bank_n;
  logic [WIDTH-1:0] mem [BANKS][TAPS];
  logic [WIDTH-1:0] rd_mux, coef_mux;
  logic [AW-1:0]    ridx;

  // Sharpen kernel for 3x3; identity (centre tap 1) for any other size.
  function automatic logic [WIDTH-1:0] rst_tap(input int k);
    if (KSIZE == 3) begin
      case (k)
        4:          return WIDTH'(5);
        1, 3, 5, 7: return '1;
        default:    return '0;
      endcase
    end
    return (k == TAPS / 2) ? WIDTH'(1) : '0;
  endfunction

  assign ridx = ADDRESS[AW+1:2];

`ifdef KERNEL_WRITE_EN
  logic [AW-1:0] widx;
  logic          wr_range, wr_ok;
  logic          unused_bits;

  assign widx        = WADDR[AW+1:2];
  assign wr_range    = (int'(WBANK) < BANKS) && (int'(widx) < TAPS);
  // The bank feeding the MAC must not change under it.
  assign wr_ok       = WE && wr_range && !(BUSY && (WBANK == bank));
  assign unused_bits = ^{ADDRESS[1:0], WADDR[1:0]};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int b = 0; b < BANKS; b++)
        for (int t = 0; t < TAPS; t++)
          mem[b][t] <= rst_tap(t);
      WERR <= 1'b0;
    end else begin
      for (int b = 0; b < BANKS; b++)
        for (int t = 0; t < TAPS; t++)
          if (wr_ok && (WBANK == BW'(b)) && (widx == AW'(t)))
            mem[b][t] <= WDATA;
      WERR <= WE && !wr_ok;
    end
  end
`else
  logic unused_bits;

  assign unused_bits = ^{ADDRESS[1:0], WE, WBANK, WADDR, WDATA};
  assign WERR        = 1'b0;

  always_comb begin
    for (int b = 0; b < BANKS; b++)
      for (int t = 0; t < TAPS; t++)
        mem[b][t] = rst_tap(t);
  end
`endif

  // Explicit match loops keep out-of-range indices at 0 instead of X.
  always_comb begin
    rd_mux   = '0;
    coef_mux = '0;
    for (int b = 0; b < BANKS; b++)
      for (int t = 0; t < TAPS; t++) begin
        if ((RBANK == BW'(b)) && (ridx == AW'(t))) rd_mux = mem[b][t];
        if ((bank == BW'(b)) && (idx == AW'(t)))   coef_mux = mem[b][t];
      end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) READ <= '0;
    else     READ <= rd_mux;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      idx   <= '0;
      bank  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      bank  <= bank_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    bank_n  = bank;
    case (state)
      IDLE: begin
        if (START && (int'(SBANK) < BANKS)) begin
          state_n = STREAM;
          idx_n   = '0;
          bank_n  = SBANK;
        end
      end
      STREAM: begin
        if (COEF_READY) begin
          if (idx == AW'(TAPS - 1)) state_n = IDLE;
          else                      idx_n   = idx + AW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign BUSY       = (state != IDLE);
  assign COEF_VALID = (state == STREAM);
  assign COEF_LAST  = (state == STREAM) && (idx == AW'(TAPS - 1));
  assign COEF       = (state == STREAM) ? coef_mux : '0;

endmodule
